controlador_minero: RTL and testbench

- Job controller placed directly upstream and downstream of the mining core (sistema_area).
- Assembles a 96-bit payload and an 8-bit target from a byte stream, then drives `active` and waits for `terminado`.
- Captures the core's nonce and hash outputs, then streams them back out as bytes.
- A watchdog aborts runs that never finish.

---
 rtl/controlador_minero.sv | 111 +++++++++++
 tb/tb_controlador_minero.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/controlador_minero.sv
// Job controller around the mining core: loads payload/target from a byte stream,
// runs the core under a watchdog, then streams {nonce, hash} back out as bytes.
module controlador_minero #(
    parameter int unsigned MAX_CICLOS = 1000000,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic [95:0]      payload,
    output logic [7:0]       target,
    output logic             active,
    input  logic             terminado,
    input  logic [31:0]      nonce_in,
    input  logic [23:0]      hash_in,
    output logic             res_valid,
    output logic [7:0]       res_data,
    input  logic             res_ready,
    output logic             timeout,
    output logic [CNT_W-1:0] ciclos
);
    // Handshakes: a byte moves on either side only in a cycle where valid and
    // ready are both high at the rising edge; valid never depends on ready.

    typedef enum logic [1:0] {CARGA, MINANDO, ENVIO} state_t;

    localparam bit              WD_EN    = (MAX_CICLOS != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CICLOS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_CICLOS);

    state_t           state;
    logic [3:0]       idx;
    logic [CNT_W-1:0] cnt;
    logic [55:0]      res_sr;
    logic             done_ok;
    logic             wd_hit;

    assign in_ready = (state == CARGA);
    assign res_data = res_sr[55:48];

    // The core may still be showing the previous job's done in the first cycle.
    assign done_ok = terminado && (cnt != '0);
    assign wd_hit  = WD_EN && (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= CARGA;
            idx       <= '0;
            cnt       <= '0;
            res_sr    <= '0;
            payload   <= '0;
            target    <= '0;
            active    <= 1'b0;
            res_valid <= 1'b0;
            timeout   <= 1'b0;
            ciclos    <= '0;
        end else begin
            case (state)
                CARGA: begin
                    if (in_valid) begin
                        if (idx == 4'd12) begin
                            target  <= in_data;
                            active  <= 1'b1;
                            cnt     <= '0;
                            timeout <= 1'b0;
                            idx     <= '0;
                            state   <= MINANDO;
                        end else begin
                            // Shifting in MSB-first leaves byte 0 in payload[95:88].
                            payload <= {payload[87:0], in_data};
                            idx     <= idx + 4'd1;
                        end
                    end
                end
                MINANDO: begin
                    if (done_ok) begin
                        res_sr    <= {nonce_in, hash_in};
                        ciclos    <= cnt + 1'b1;
                        active    <= 1'b0;
                        res_valid <= 1'b1;
                        state     <= ENVIO;
                    end else if (wd_hit) begin
                        res_sr    <= '1;
                        timeout   <= 1'b1;
                        ciclos    <= CNT_MAX;
                        active    <= 1'b0;
                        res_valid <= 1'b1;
                        state     <= ENVIO;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ENVIO: begin
                    if (res_ready) begin
                        res_sr <= {res_sr[47:0], 8'h00};
                        if (idx == 4'd6) begin
                            res_valid <= 1'b0;
                            idx       <= '0;
                            state     <= CARGA;
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end
                end
                default: state <= CARGA;
            endcase
        end
    end
endmodule

// File: tb/tb_controlador_minero.sv
// Bench for controlador_minero: a long-budget instance and a MAX_CICLOS=8 instance
// share stimulus; result bytes are checked against a scoreboard queue.
module tb_controlador_minero;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        terminado;
    logic [31:0] nonce_in;
    logic [23:0] hash_in;
    logic        res_ready;

    logic        in_ready, active, res_valid, timeout;
    logic [95:0] payload;
    logic [7:0]  target, res_data;
    logic [31:0] ciclos;

    logic        in_ready_w, active_w, res_valid_w, timeout_w;
    logic [95:0] payload_w;
    logic [7:0]  target_w, res_data_w;
    logic [31:0] ciclos_w;

    logic [7:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    controlador_minero dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .payload(payload), .target(target), .active(active),
        .terminado(terminado), .nonce_in(nonce_in), .hash_in(hash_in),
        .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
        .timeout(timeout), .ciclos(ciclos)
    );

    controlador_minero #(.MAX_CICLOS(8), .CNT_W(32)) dut_w (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_w), .payload(payload_w), .target(target_w), .active(active_w),
        .terminado(terminado), .nonce_in(nonce_in), .hash_in(hash_in),
        .res_valid(res_valid_w), .res_data(res_data_w), .res_ready(res_ready),
        .timeout(timeout_w), .ciclos(ciclos_w)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [95:0] p, input logic [7:0] t, input bit gaps);
        logic [7:0] b;
        for (int i = 0; i < 13; i++) begin
            if (gaps && $urandom_range(0, 1) == 1) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom_range(0, 255));
                tick();
            end
            b = (i < 12) ? p[95 - 8*i -: 8] : t;
            in_valid = 1'b1;
            in_data  = b;
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic push_result(input logic [31:0] n, input logic [23:0] h);
        logic [55:0] r;
        r = {n, h};
        for (int k = 0; k < 7; k++) exp_q.push_back(r[55 - 8*k -: 8]);
    endtask

    // Entered right after the accept edge of byte 12; done is sampled at edge done_at.
    task automatic finish_job(input int done_at, input logic [31:0] n, input logic [23:0] h);
        repeat (done_at - 1) tick();
        terminado = 1'b1;
        nonce_in  = n;
        hash_in   = h;
        push_result(n, h);
        tick();
        terminado = 1'b0;
    endtask

    task automatic drain(input bit sel, input bit toggle, input bit poke);
        logic v, rdy;
        logic [7:0] d, held, e;
        bit pend;
        int budget;
        pend = 1'b0;
        held = '0;
        budget = 0;
        res_ready = 1'b1;
        while (exp_q.size() != 0 && budget < 200) begin
            if (poke) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = 8'($urandom_range(0, 255));
            end
            @(negedge clk);
            v   = sel ? res_valid_w : res_valid;
            d   = sel ? res_data_w : res_data;
            rdy = sel ? in_ready_w : in_ready;
            if (pend) begin
                n_checks++;
                if (d !== held) begin
                    n_fail++;
                    $display("FAIL hold_res_data: got %h required %h", d, held);
                end
            end
            if (poke && v) begin
                n_checks++;
                if (rdy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL in_ready_envio: got %b required 0", rdy);
                end
            end
            if (v && res_ready) begin
                e = exp_q.pop_front();
                n_checks++;
                if (d !== e) begin
                    n_fail++;
                    $display("FAIL res_byte: got %h required %h", d, e);
                end
            end
            pend = v && !res_ready;
            held = d;
            tick();
            if (toggle) res_ready = ~res_ready;
            budget++;
        end
        in_valid  = 1'b0;
        res_ready = 1'b0;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d bytes left required 0", exp_q.size());
            exp_q.delete();
        end
        v   = sel ? res_valid_w : res_valid;
        rdy = sel ? in_ready_w : in_ready;
        n_checks++;
        if (v !== 1'b0 || rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL after_drain: got res_valid=%b in_ready=%b required 0/1", v, rdy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0; in_data = '0; terminado = 1'b0;
        nonce_in = '0; hash_in = '0; res_ready = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        n_checks++;
        if ({payload, target, active, res_valid, res_data, timeout, ciclos, in_ready} !==
            {96'h0, 8'h0, 1'b0, 1'b0, 8'h0, 1'b0, 32'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_state: got p=%h t=%h a=%b rv=%b rd=%h to=%b c=%0d ir=%b required zeros, in_ready=1",
                     payload, target, active, res_valid, res_data, timeout, ciclos, in_ready);
        end
    endtask

    task automatic test_load();
        test_reset();
        load(96'h397d9f2f40ca9e6c6b1f3324, 8'h0a, 1'b0);
        n_checks++;
        if (payload !== 96'h397d9f2f40ca9e6c6b1f3324 || target !== 8'h0a) begin
            n_fail++;
            $display("FAIL load_data: got %h/%h required 397d9f2f40ca9e6c6b1f3324/0a", payload, target);
        end
        n_checks++;
        if (active !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL load_active: got active=%b in_ready=%b required 1/0", active, in_ready);
        end
    endtask

    task automatic test_full_job();
        test_reset();
        load(96'h397d9f2f40ca9e6c6b1f3324, 8'h0a, 1'b0);
        repeat (19) tick();
        n_checks++;
        if (active !== 1'b1) begin
            n_fail++;
            $display("FAIL job_active_held: got %b required 1", active);
        end
        terminado = 1'b1;
        nonce_in = 32'h0000_0123;
        hash_in  = 24'h0A_1B2C;
        push_result(32'h0000_0123, 24'h0A_1B2C);
        tick();
        terminado = 1'b0;
        n_checks++;
        if (active !== 1'b0 || ciclos !== 32'd20 || timeout !== 1'b0 || res_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL job_done: got a=%b c=%0d to=%b rv=%b required 0/20/0/1",
                     active, ciclos, timeout, res_valid);
        end
        drain(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_stale_done();
        test_reset();
        terminado = 1'b1;
        nonce_in = 32'hDEAD_BEEF;
        hash_in  = 24'h12_3456;
        load(96'h0123456789abcdef00112233, 8'h33, 1'b0);
        tick();
        terminado = 1'b0;
        n_checks++;
        if (active !== 1'b1 || res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stale_ignored: got active=%b res_valid=%b required 1/0", active, res_valid);
        end
        repeat (3) tick();
        terminado = 1'b1;
        push_result(32'hDEAD_BEEF, 24'h12_3456);
        tick();
        terminado = 1'b0;
        n_checks++;
        if (active !== 1'b0 || ciclos !== 32'd5) begin
            n_fail++;
            $display("FAIL stale_capture: got active=%b ciclos=%0d required 0/5", active, ciclos);
        end
        drain(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        test_reset();
        load(96'hfedcba9876543210a5a55a5a, 8'hc3, 1'b0);
        finish_job(6, 32'h8001_7FFE, 24'hC0_FFEE);
        drain(1'b0, 1'b1, 1'b1);
        n_checks++;
        if (payload !== 96'hfedcba9876543210a5a55a5a || target !== 8'hc3) begin
            n_fail++;
            $display("FAIL payload_kept: got %h/%h required fedcba9876543210a5a55a5a/c3", payload, target);
        end
    endtask

    task automatic test_watchdog();
        test_reset();
        load(96'h111111112222222233333333, 8'h01, 1'b0);
        repeat (7) tick();
        n_checks++;
        if (active_w !== 1'b1) begin
            n_fail++;
            $display("FAIL wd_early: got active=%b required 1", active_w);
        end
        for (int k = 0; k < 7; k++) exp_q.push_back(8'hFF);
        tick();
        n_checks++;
        if (active_w !== 1'b0 || timeout_w !== 1'b1 || ciclos_w !== 32'd8 || res_valid_w !== 1'b1) begin
            n_fail++;
            $display("FAIL wd_expire: got a=%b to=%b c=%0d rv=%b required 0/1/8/1",
                     active_w, timeout_w, ciclos_w, res_valid_w);
        end
        drain(1'b1, 1'b1, 1'b0);
        n_checks++;
        if (timeout_w !== 1'b1 || ciclos_w !== 32'd8) begin
            n_fail++;
            $display("FAIL wd_status_kept: got to=%b c=%0d required 1/8", timeout_w, ciclos_w);
        end
    endtask

    task automatic test_watchdog_tie();
        test_reset();
        load(96'h444444445555555566666666, 8'h02, 1'b0);
        finish_job(8, 32'hCAFE_0001, 24'hAB_CDEF);
        n_checks++;
        if (active_w !== 1'b0 || timeout_w !== 1'b0 || ciclos_w !== 32'd8) begin
            n_fail++;
            $display("FAIL wd_tie: got a=%b to=%b c=%0d required 0/0/8", active_w, timeout_w, ciclos_w);
        end
        drain(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_job();
        test_reset();
        load(96'h777777778888888899999999, 8'h03, 1'b0);
        repeat (3) tick();
        reset = 1'b1;
        #1;
        n_checks++;
        if (active !== 1'b0 || payload !== 96'h0 || res_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid: got a=%b p=%h rv=%b ir=%b required 0/0/0/1",
                     active, payload, res_valid, in_ready);
        end
        tick();
        reset = 1'b0;
        load(96'h0badc0de1234567890abcdef, 8'h5a, 1'b1);
        n_checks++;
        if (payload !== 96'h0badc0de1234567890abcdef || target !== 8'h5a || active !== 1'b1) begin
            n_fail++;
            $display("FAIL reload: got p=%h t=%h a=%b required 0badc0de1234567890abcdef/5a/1",
                     payload, target, active);
        end
        finish_job(3, 32'h1357_9BDF, 24'h24_68AC);
        n_checks++;
        if (ciclos !== 32'd3 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL reload_job: got ciclos=%0d timeout=%b required 3/0", ciclos, timeout);
        end
        drain(1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_load();
        test_full_job();
        test_stale_done();
        test_backpressure();
        test_watchdog();
        test_watchdog_tie();
        test_reset_mid_job();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
